uart_frame_assembler: RTL
=========================

// Module: uart_frame_assembler
// PURPOSE
//  Collects the byte stream from the UART receiver into one 32-byte decrypt frame.
//  - Bytes 0..15 form the RSA-wrapped AES key block.
//  - Bytes 16..31 form the AES ciphertext block.
//  Presents both 128-bit blocks together with a valid/ready handshake.
//  Sits between the UART RX byte receiver and the RSA/AES decrypt core in the Basys3 top level.
// PARAMETERS
//  BLOCK_BYTES     16     bytes per 128-bit block; frame = 2*BLOCK_BYTES
//  TIMEOUT_CYCLES  34720  inter-byte idle limit in clk cycles (4 char times @115200, 100 MHz)
// PORTS
//  clk          in   1    system clock, 100 MHz
//  rst_n        in   1    asynchronous active-low reset
//  rx_valid     in   1    1-cycle strobe: rx_data holds a new received byte
//  rx_data      in   8    received byte
//  key_out      out  128  key block; first received byte in [127:120]
//  ct_out       out  128  ciphertext block; byte 16 in [127:120]
//  blk_valid    out  1    key_out/ct_out hold a complete frame
//  blk_ready    in   1    decrypt core accepts the frame when blk_valid & blk_ready
//  byte_cnt     out  5    bytes stored in the current block (0..15)
//  busy         out  1    1 in S_CT, or in S_KEY with byte_cnt != 0
//  overrun      out  1    sticky: a byte was dropped in S_HOLD; cleared only by reset
//  timeout_evt  out  1    1-cycle pulse when a partial frame is discarded
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=S_KEY; all outputs 0, including key_out/ct_out.
//   - Reset mid-frame discards all partial data.
//  FSM states: S_KEY -> S_CT -> S_HOLD -> S_KEY.
//  S_KEY:
//   - Each rx_valid shifts the key register left 8 bits and inserts rx_data in [7:0], so the MSB-first order holds after 16 bytes.
//   - byte_cnt increments on each byte.
//   - On the 16th byte: byte_cnt->0, go to S_CT.
//  S_CT:
//   - Same shifting into ct_out.
//   - On the 16th byte: go to S_HOLD; blk_valid=1 from the next cycle (1-cycle latency after the last byte strobe).
//  S_HOLD:
//   - key_out/ct_out/blk_valid stay stable until blk_valid & blk_ready.
//   - On handshake: next cycle blk_valid=0, state=S_KEY, byte_cnt=0.
//   - rx_valid without handshake: byte dropped, overrun<=1; registers unchanged.
//   - rx_valid in the handshake cycle: byte is accepted as key byte 0 of the next frame; next state S_KEY, byte_cnt=1, key reg = {120'b0, rx_data}.
//  Data registers:
//   - Are not cleared between frames; only bytes of the new frame fill them.
//   - key_out/ct_out are the shift registers themselves and are valid only while blk_valid=1.
//  byte_cnt is a 5-bit counter that wraps 15->0 at each block boundary; it never shows 16.
//  rx_valid on consecutive cycles must be accepted on every cycle (no throughput gaps).
// CONFIGURATION
//  Macro UART_FRAME_TIMEOUT_EN.
//  Defined:
//   - An idle counter runs while busy=1, cleared on each accepted byte.
//   - When it reaches TIMEOUT_CYCLES-1 with no byte: timeout_evt pulses 1 cycle, state->S_KEY, byte_cnt->0.
//   - Counter is held at 0 in S_HOLD and when not busy.
//   - A byte arriving in the same cycle as expiry wins: it is accepted, no timeout.
//  Undefined:
//   - No counter is synthesised; timeout_evt tied 0.
//   - A partial frame waits indefinitely.
// STRUCTURE
//  Package uart_frame_pkg:
//   - typedef enum logic [1:0] {S_KEY, S_CT, S_HOLD} frame_state_t
//   - typedef logic [127:0] block_t
//   - localparam FRAME_BYTES = 32
//  Sub-module byte_shift_reg:
//   - 128-bit shift-in register with load-enable and clear.
//   - Instantiated twice: one key register, one ciphertext register.
//  The FSM and counters live in the top module.
// TESTING
//  1. Send the 16 bytes of 12345678987654321234567898765432, then 08938A533D49A4F5DD8C42A3717876DA (rx_valid spaced 10 clk), blk_ready=1.
//     -> blk_valid pulses for 1 cycle, 1 cycle after the 32nd strobe; key_out/ct_out equal those values; overrun=0.
//  2. Same frame with blk_ready=0, then 3 extra bytes AA,BB,CC, then blk_ready=1.
//     -> outputs unchanged, overrun=1 stays set; next frame assembles correctly from byte 0.
//  3. Hold blk_valid, then assert blk_ready and rx_valid (data 5A) in the same cycle.
//     -> next cycle blk_valid=0, byte_cnt=1, key_out[7:0]=5A, overrun unchanged.
//  4. Send 20 bytes, pulse rst_n low mid-byte-21, then send a full frame.
//     -> all outputs 0 during reset; the following frame is correct and has no stale bytes.
//  5. With UART_FRAME_TIMEOUT_EN: send 7 bytes, idle TIMEOUT_CYCLES, then send a full frame.
//     -> timeout_evt 1 pulse, byte_cnt=0, busy=0; the new frame is correct.
//     Without the macro: no pulse, byte_cnt stays 7.
//  6. Send 32 back-to-back rx_valid on consecutive cycles (bytes 00..1F).
//     -> key_out=000102..0F, ct_out=101112..1F; no byte lost.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// ============================================================================
//  Module   : uart_frame_pkg
//  Purpose  : Shared types and sizes for the UART decrypt-frame assembler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_frame_pkg;

    typedef enum logic [1:0] {
        S_KEY  = 2'd0,
        S_CT   = 2'd1,
        S_HOLD = 2'd2
    } frame_state_t;

    typedef logic [127:0] block_t;

    localparam int FRAME_BYTES = 32;

endpackage

`default_nettype wire

// File: rtl/byte_shift_reg.sv
// ============================================================================
//  Module   : byte_shift_reg
//  Purpose  : 128-bit byte-wide shift-in register with load enable and clear.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module byte_shift_reg
    import uart_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] din,
    output block_t     q
);

    block_t r_q;
    block_t w_base;

    // clear together with load starts a fresh block holding only din
    assign w_base = clr ? '0 : r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= {w_base[119:0], din};
        end else if (clr) begin
            r_q <= '0;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/uart_frame_assembler.sv
// ============================================================================
//  Module   : uart_frame_assembler
//  Purpose  : Packs the UART byte stream into a 32-byte key+ciphertext frame
//             with valid/ready hand-off. Optional inter-byte idle timeout is
//             enabled by defining UART_FRAME_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_frame_assembler
    import uart_frame_pkg::*;
#(
    parameter int BLOCK_BYTES    = FRAME_BYTES / 2,
    parameter int TIMEOUT_CYCLES = 34720
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic [127:0] key_out,
    output logic [127:0] ct_out,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [4:0]   byte_cnt,
    output logic         busy,
    output logic         overrun,
    output logic         timeout_evt
);

    frame_state_t r_state;
    frame_state_t w_state_nxt;
    logic [4:0]   r_byte_cnt;
    logic [4:0]   w_cnt_nxt;
    logic         r_overrun;
    logic         w_key_ld;
    logic         w_key_clr;
    logic         w_ct_ld;
    logic         w_ovr_set;
    logic         w_last;
    logic         w_busy;
    logic         w_expire;

    assign w_last = (r_byte_cnt == 5'(BLOCK_BYTES - 1));
    assign w_busy = (r_state == S_CT) || ((r_state == S_KEY) && (r_byte_cnt != 5'd0));

    byte_shift_reg u_key_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_key_clr),
        .load  (w_key_ld),
        .din   (rx_data),
        .q     (key_out)
    );

    byte_shift_reg u_ct_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .load  (w_ct_ld),
        .din   (rx_data),
        .q     (ct_out)
    );

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int c_IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_IDLE_W-1:0] r_idle;
    logic                r_timeout;

    // an arriving byte always beats an expiring counter
    assign w_expire = w_busy && !rx_valid && (r_idle == c_IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (!w_busy || rx_valid || w_expire) begin
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + c_IDLE_W'(1);
            end
        end
    end

    assign timeout_evt = r_timeout;
`else
    logic [31:0] w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign w_expire             = 1'b0;
    assign timeout_evt          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_KEY;
            r_byte_cnt <= 5'd0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_cnt_nxt;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_byte_cnt;
        w_key_ld    = 1'b0;
        w_key_clr   = 1'b0;
        w_ct_ld     = 1'b0;
        w_ovr_set   = 1'b0;
        case (r_state)
            S_KEY: begin
                if (rx_valid) begin
                    w_key_ld = 1'b1;
                    if (w_last) begin
                        w_cnt_nxt   = 5'd0;
                        w_state_nxt = S_CT;
                    end else begin
                        w_cnt_nxt = r_byte_cnt + 5'd1;
                    end
                end else if (w_expire) begin
                    w_cnt_nxt = 5'd0;
                end
            end
            S_CT: begin
                if (rx_valid) begin
                    w_ct_ld = 1'b1;
                    if (w_last) begin
                        w_cnt_nxt   = 5'd0;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_cnt_nxt = r_byte_cnt + 5'd1;
                    end
                end else if (w_expire) begin
                    w_cnt_nxt   = 5'd0;
                    w_state_nxt = S_KEY;
                end
            end
            S_HOLD: begin
                if (blk_ready) begin
                    w_state_nxt = S_KEY;
                    w_cnt_nxt   = 5'd0;
                    if (rx_valid) begin
                        w_key_clr = 1'b1;
                        w_key_ld  = 1'b1;
                        w_cnt_nxt = 5'd1;
                    end
                end else if (rx_valid) begin
                    w_ovr_set = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_KEY;
                w_cnt_nxt   = 5'd0;
            end
        endcase
    end

    assign blk_valid = (r_state == S_HOLD);
    assign byte_cnt  = r_byte_cnt;
    assign busy      = w_busy;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire
